// File: rtl/mem_responder.sv
// mem_responder: fixed-latency, single-outstanding memory model for the
// multicycle core's memory port, with a backdoor preload port.
module mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err,
  input  logic        bd_we,
  input  logic [31:0] bd_addr,
  input  logic [31:0] bd_wdata,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  // Wide enough to hold LATENCY-1
  localparam int unsigned CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [CNT_W-1:0] lat_cnt, lat_cnt_next;

  logic             req_rd, req_wr;
  logic [3:0]       req_be;
  logic [31:0]      req_addr, req_wdata;

  logic             cur_rd, cur_wr;
  logic [3:0]       cur_be;
  logic [31:0]      cur_addr, cur_wdata, cur_off;
  logic             cur_in_range, cur_legal;
  logic [IDX_W-1:0] cur_idx;

  logic [31:0]      bd_off;
  logic             bd_in_range;
  logic [IDX_W-1:0] bd_idx;

  logic             accept, commit;

  // Request view: live inputs in IDLE (needed for LATENCY=1), latched copy afterwards
  always_comb begin
    cur_rd       = req_rd;
    cur_wr       = req_wr;
    cur_be       = req_be;
    cur_addr     = req_addr;
    cur_wdata    = req_wdata;
    if (state == IDLE) begin
      cur_rd    = mem_read;
      cur_wr    = mem_write;
      cur_be    = mem_byte_enable;
      cur_addr  = mem_address;
      cur_wdata = mem_wdata;
    end
    cur_off      = cur_addr - BASE_ADDR;
    cur_in_range = (cur_off < SPAN_BYTES);
    cur_idx      = cur_off[IDX_W+1:2];
    cur_legal    = cur_in_range && !(cur_rd && cur_wr);
    bd_off       = bd_addr - BASE_ADDR;
    bd_in_range  = (bd_off < SPAN_BYTES);
    bd_idx       = bd_off[IDX_W+1:2];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (mem_read || mem_write) state_next = (LATENCY == 1) ? RESP : BUSY;
      BUSY: if (lat_cnt == CNT_W'(1)) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM control outputs: acceptance, commit strobe and latency counter update
  always_comb begin
    accept       = (state == IDLE) && (mem_read || mem_write) && !rst;
    commit       = (state != RESP) && (state_next == RESP) && !rst;
    lat_cnt_next = lat_cnt;
    if (accept)             lat_cnt_next = CNT_LOAD;
    else if (state == BUSY) lat_cnt_next = lat_cnt - CNT_W'(1);
  end

  // Request latch, response registers and completion counters
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt   <= '0;
      req_rd    <= 1'b0;
      req_wr    <= 1'b0;
      req_be    <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      mem_resp  <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      lat_cnt  <= lat_cnt_next;
      mem_resp <= commit;
      mem_err  <= commit && !cur_legal;
      if (accept) begin
        req_rd    <= mem_read;
        req_wr    <= mem_write;
        req_be    <= mem_byte_enable;
        req_addr  <= mem_address;
        req_wdata <= mem_wdata;
      end
      if (commit) begin
        if (!cur_legal) begin
          mem_rdata <= '0;
        end else if (cur_rd) begin
          mem_rdata <= mem[cur_idx];
          rd_count  <= rd_count + 16'd1;
        end else begin
          wr_count  <= wr_count + 16'd1;
        end
      end
    end
  end

  // Array writes: backdoor full word first, bus lanes override on a same-word collision
  always_ff @(posedge clk) begin
    if (bd_we && bd_in_range) mem[bd_idx] <= bd_wdata;
    if (commit && cur_legal && cur_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

endmodule
